// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK SPI responder: frame length, command
// prefix, FSM states and the TX frame builder.
package jstk_pkg;

  localparam int         FRAME_BITS = 40;
  localparam logic [5:0] CMD_PREFIX = 6'b100000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Little-endian 10-bit values, each split into a low byte and a 2-bit high byte.
  function automatic logic [FRAME_BITS-1:0] build_tx(input logic [9:0] x,
                                                     input logic [9:0] y,
                                                     input logic [2:0] btn);
    return {x[7:0], 6'b000000, x[9:8], y[7:0], 6'b000000, y[9:8], 5'b00000, btn};
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI line with rise/fall
// detection on the synchronized value.
module spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout_s,
  output logic rise_s,
  output logic fall_s
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{RST_VAL}};
      prev_r <= RST_VAL;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign dout_s = sync_r[SYNC_STAGES-1];
  assign rise_s = dout_s & ~prev_r;
  assign fall_s = ~dout_s & prev_r;

endmodule

// File: rtl/pmodjstk_responder.sv
// SPI mode-0 slave emulating the PmodJSTK joystick: serves a 5-byte X/Y/button
// frame on MISO and decodes the master's command byte into LED state.
// Optional SS-low watchdog enabled by defining JSTK_SS_TIMEOUT_EN.
module pmodjstk_responder
  import jstk_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef JSTK_SS_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] X_Pos,
  input  logic [9:0] Y_Pos,
  input  logic [2:0] Buttons,
  output logic [1:0] LED_Out,
  output logic       Frame_Done,
  output logic       Frame_Error
);

  localparam int                CNT_W    = 6;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  SAT_CNT  = CNT_W'(FRAME_BITS + 1);

  logic ss_s, ss_rise_s, ss_fall_s;
  logic sclk_s, sclk_rise_s, sclk_fall_s;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_r;

  state_t                 state_r, state_nxt;
  logic [FRAME_BITS-1:0]  tx_r, tx_nxt;
  logic [FRAME_BITS-1:0]  rx_r, rx_nxt;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt;
  logic [1:0]             led_r, led_nxt;
  logic                   miso_r, miso_nxt;
  logic                   done_r, done_nxt;
  logic                   err_r, err_nxt;
  logic                   tmo_hit_s;

  // SS idles high, so its synchronizer resets high to avoid a false fall.
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(Clk), .rst(Reset), .din(SS),
    .dout_s(ss_s), .rise_s(ss_rise_s), .fall_s(ss_fall_s)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(Clk), .rst(Reset), .din(SCLK),
    .dout_s(sclk_s), .rise_s(sclk_rise_s), .fall_s(sclk_fall_s)
  );

  // MOSI synchronizer, same depth as SCLK so data and clock stay aligned.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

`ifdef JSTK_SS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_r;

  // Watchdog: restarts on every SCLK edge and on entry into SHIFT.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tmo_r <= {TMO_W{1'b0}};
    end else if ((state_r != SHIFT) || sclk_rise_s || sclk_fall_s) begin
      tmo_r <= {TMO_W{1'b0}};
    end else begin
      tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end
  end

  assign tmo_hit_s = (state_r == SHIFT) && !ss_rise_s && !sclk_rise_s && !sclk_fall_s &&
                     (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (ss_fall_s) state_nxt = SHIFT;
        else           state_nxt = IDLE;
      end
      SHIFT: begin
        if (ss_rise_s)      state_nxt = DONE;
        else if (tmo_hit_s) state_nxt = IDLE;
        else                state_nxt = SHIFT;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values; SCLK edges coinciding with an SS edge are dropped.
  always_comb begin
    tx_nxt   = tx_r;
    rx_nxt   = rx_r;
    cnt_nxt  = cnt_r;
    led_nxt  = led_r;
    done_nxt = 1'b0;
    err_nxt  = tmo_hit_s;
    miso_nxt = 1'b0;
    case (state_r)
      IDLE: begin
        if (ss_fall_s) begin
          tx_nxt  = build_tx(X_Pos, Y_Pos, Buttons);
          rx_nxt  = {FRAME_BITS{1'b0}};
          cnt_nxt = {CNT_W{1'b0}};
        end else begin
          tx_nxt  = tx_r;
        end
      end
      SHIFT: begin
        if (ss_rise_s) begin
          cnt_nxt = cnt_r;
        end else if (sclk_rise_s) begin
          rx_nxt = {rx_r[FRAME_BITS-2:0], mosi_s};
          if (cnt_r != SAT_CNT) cnt_nxt = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          else                  cnt_nxt = cnt_r;
        end else if (sclk_fall_s) begin
          tx_nxt = {tx_r[FRAME_BITS-2:0], 1'b0};
        end else begin
          tx_nxt = tx_r;
        end
      end
      DONE: begin
        if (cnt_r == FULL_CNT) begin
          done_nxt = 1'b1;
          if (rx_r[FRAME_BITS-1 -: 6] == CMD_PREFIX) led_nxt = rx_r[FRAME_BITS-7 -: 2];
          else                                         led_nxt = led_r;
        end else begin
          err_nxt = 1'b1;
        end
      end
      default: begin
        tx_nxt = tx_r;
      end
    endcase
    if ((state_nxt == SHIFT) && (cnt_nxt < FULL_CNT)) miso_nxt = tx_nxt[FRAME_BITS-1];
    else                                              miso_nxt = 1'b0;
  end

  // Datapath and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tx_r   <= {FRAME_BITS{1'b0}};
      rx_r   <= {FRAME_BITS{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      led_r  <= 2'b00;
      miso_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      tx_r   <= tx_nxt;
      rx_r   <= rx_nxt;
      cnt_r  <= cnt_nxt;
      led_r  <= led_nxt;
      miso_r <= miso_nxt;
      done_r <= done_nxt;
      err_r  <= err_nxt;
    end
  end

  assign MISO        = miso_r;
  assign LED_Out     = led_r;
  assign Frame_Done  = done_r;
  assign Frame_Error = err_r;

endmodule
